// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard interface: decode operand/destination info in, bypass selects and stall out.
// The master drives decode/flush/freeze inputs; the slave (hazard_ctrl) returns bypass and stall.
interface hazard_ctrl_if #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_BITS  = 16
);
  logic                 D_valid;
  logic [ADDR_SIZE-1:0] D_ra;
  logic [ADDR_SIZE-1:0] D_rb;
  logic                 D_use_ra;
  logic                 D_use_rb;
  logic [ADDR_SIZE-1:0] D_rd;
  logic                 D_we;
  logic                 D_ld;
  logic                 D_jlx;
  logic                 flush;
  logic                 MEM_stall;

  logic [1:0]           EX_D_bp;
  logic [1:0]           MEM_D_bp;
  logic [1:0]           WB_D_bp;
  logic                 D_stall;
  logic                 EX_bubble;
  logic [CNT_BITS-1:0]  stall_cnt;

  modport master (
    output D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld, D_jlx,
           flush, MEM_stall,
    input  EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, EX_bubble, stall_cnt
  );

  modport slave (
    input  D_valid, D_ra, D_rb, D_use_ra, D_use_rb, D_rd, D_we, D_ld, D_jlx,
           flush, MEM_stall,
    output EX_D_bp, MEM_D_bp, WB_D_bp, D_stall, EX_bubble, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control beside decode: tracks EX/MEM/WB destination tags, selects one-hot bypass per operand.
// Bypass and stall are combinational; slots advance every edge unless MEM_stall freezes the pipe.
module hazard_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_BITS  = 16
) (
  input logic        clk,
  input logic        rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [ADDR_SIZE-1:0] LINK_REG = ADDR_SIZE'(31);

  typedef struct packed {
    logic                 v;
    logic [ADDR_SIZE-1:0] rd;
    logic                 ld;
    logic                 jlx;
  } slot_t;

  typedef struct packed {
    logic ex;
    logic mem;
    logic wb;
    logic ld_use;
    logic jlx_haz;
  } op_res_t;

  slot_t               ex_q, mem_q, wb_q;
  slot_t               dec_slot;
  logic                bubble_q;
  logic [CNT_BITS-1:0] cnt_q;
  op_res_t             res_a, res_b;
  logic                hazard;
  logic                d_stall;
  logic                load_dec;

  function automatic logic slot_hit(input slot_t s, input logic [ADDR_SIZE-1:0] src,
                                    input logic use_src);
    return s.v && (s.rd == src) && (src != '0) && use_src;
  endfunction

  // Priority EX > MEM > WB; a load or link slot in a higher stage masks older matches.
  function automatic op_res_t resolve(input slot_t ex, input slot_t mem, input slot_t wb,
                                      input logic [ADDR_SIZE-1:0] src, input logic use_src);
    op_res_t r;
    logic    h_ex, h_mem, h_wb;
    r       = '0;
    h_ex    = slot_hit(ex, src, use_src);
    h_mem   = slot_hit(mem, src, use_src);
    h_wb    = slot_hit(wb, src, use_src);
    r.jlx_haz = (h_ex && ex.jlx) || (h_mem && mem.jlx) || (h_wb && wb.jlx);
    if (h_ex) begin
      if (ex.jlx)     r.ex     = 1'b0;
      else if (ex.ld) r.ld_use = 1'b1;
      else            r.ex     = 1'b1;
    end else if (h_mem) begin
      r.mem = !mem.jlx;
    end else if (h_wb) begin
      r.wb = !wb.jlx;
    end
    return r;
  endfunction

  always_comb begin
    res_a = resolve(ex_q, mem_q, wb_q, hz.D_ra, hz.D_use_ra);
    res_b = resolve(ex_q, mem_q, wb_q, hz.D_rb, hz.D_use_rb);
  end

  assign hazard  = res_a.ld_use | res_a.jlx_haz | res_b.ld_use | res_b.jlx_haz;
  assign d_stall = hz.MEM_stall | hazard;

  // Link writes always target r31, whatever the rd field says.
  always_comb begin
    dec_slot     = '0;
    dec_slot.v   = (hz.D_we && (hz.D_rd != '0)) || hz.D_jlx;
    dec_slot.rd  = hz.D_jlx ? LINK_REG : hz.D_rd;
    dec_slot.ld  = hz.D_ld;
    dec_slot.jlx = hz.D_jlx;
  end

  assign load_dec = hz.D_valid && !d_stall && !hz.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      bubble_q <= 1'b0;
    end else if (!hz.MEM_stall) begin
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q     <= load_dec ? dec_slot : '0;
      bubble_q <= hz.D_valid && (d_stall || hz.flush);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (d_stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hz.EX_D_bp   = {res_a.ex,  res_b.ex};
  assign hz.MEM_D_bp  = {res_a.mem, res_b.mem};
  assign hz.WB_D_bp   = {res_a.wb,  res_b.wb};
  assign hz.D_stall   = d_stall;
  assign hz.EX_bubble = bubble_q;
  assign hz.stall_cnt = cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that drives the bypass enables and the decode stall for the register file.
- Tracks destination tags of the instructions in EX, MEM and WB and compares them with the decode source registers.
- Produces a one-hot bypass select per operand, a load-use stall, a jump-and-link stall on r31 and bubble insertion. It also freezes on a data-memory stall and keeps a saturating stall counter.
- Sits beside the decode stage; its bypass outputs connect directly to the regfile bypass inputs.

Parameters:
- ADDR_SIZE, 5, register index width.
- CNT_BITS, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- D_valid  in  1  decode holds a real instruction.
- D_ra  in  ADDR_SIZE  source A index.
- D_rb  in  ADDR_SIZE  source B index.
- D_use_ra  in  1  instruction reads ra.
- D_use_rb  in  1  instruction reads rb.
- D_rd  in  ADDR_SIZE  destination index.
- D_we  in  1  instruction writes rd.
- D_ld  in  1  instruction is a load.
- D_jlx  in  1  instruction writes r31 with pc+4.
- flush  in  1  branch redirect; kills the decode instruction.
- MEM_stall  in  1  data memory not ready; whole pipe freezes.
- EX_D_bp  out  2  {ra,rb} select EX result.
- MEM_D_bp  out  2  {ra,rb} select MEM data.
- WB_D_bp  out  2  {ra,rb} select WB data.
- D_stall  out  1  hold fetch/decode this cycle.
- EX_bubble  out  1  EX entry loaded this cycle is a bubble (registered).
- stall_cnt  out  CNT_BITS  cycles with D_stall=1, saturating.

Behaviour:
- State: three tag slots (EX, MEM, WB). Each slot holds {v, rd, ld, jlx}, where v = valid & writes a register.
- Reset: all v=0, EX_bubble=0, stall_cnt=0. With all slots invalid, every bypass output and D_stall are 0.
- hit(slot,src): slot.v & slot.rd==src & src!=0 & use_src. jlx slots compare against rd=31 regardless of D_rd.
- Bypass outputs are combinational from the slots and decode inputs. Each operand bit is one-hot with priority EX > MEM > WB; at most one of EX/MEM/WB is set for a given bit.
  - EX hit on a non-load, non-jlx slot -> EX bit.
  - MEM hit on a non-jlx slot, load or ALU -> MEM bit.
  - WB hit on a non-jlx slot -> WB bit. This covers the write-then-read in the same cycle.
- Load-use: EX hit with EX.ld=1 -> D_stall=1 and no bypass bit for that operand. A lower-priority older match must not be selected.
- jlx: a hit on any jlx slot -> D_stall=1 until that slot leaves WB. pc+4 is never bypassed.
- MEM_stall=1 -> D_stall=1 and all slots hold. Bypass outputs keep being evaluated from the held slots.
- D_stall = MEM_stall | load-use | jlx hazard. Asserting it is a pure combinational decision for the current cycle.
- Advance, when MEM_stall=0, on the clock edge:
  - WB <= MEM, MEM <= EX.
  - EX <= decode info if D_valid & !D_stall & !flush; otherwise a bubble (v=0).
  - EX_bubble <= 1 when a bubble is loaded because of D_valid & (D_stall | flush); otherwise 0.
  - v is D_we & D_rd!=0, or D_jlx.
- While MEM_stall=1, EX_bubble holds its value.
- flush and a hazard stall in the same cycle: flush wins and a bubble is loaded. flush during MEM_stall is ignored; the redirect holds flush until the freeze ends.
- stall_cnt increments by 1 each cycle D_stall=1, stops at all-ones, and clears only on rst.
- Reset mid-operation clears all slots the next edge. No stale bypass survives.

Test Plan:
- Back-to-back ALU ops: write r5, then read r5 as ra -> EX_D_bp=2'b10, D_stall=0. The following instruction reads r5 as rb -> MEM_D_bp=2'b01.
- Load r7, then add reading r7 -> D_stall=1 for 1 cycle and EX_bubble=1. The next cycle gives MEM_D_bp=2'b10 with D_stall=0; stall_cnt=1.
- Same register r3 written by the EX, MEM and WB slots simultaneously, with decode reading r3 on both operands -> EX_D_bp=2'b11, MEM_D_bp=2'b00, WB_D_bp=2'b00.
- Source r0 with a matching rd=0 writer (D_we=1) -> all bypass outputs 0 and D_stall=0.
- jlx in EX, then decode reading r31 -> D_stall=1 for 3 cycles (slot in EX, MEM, WB). The read is released on the 4th cycle with all bypass outputs 0.
- MEM_stall held 4 cycles with a hit pending in MEM -> slots frozen, MEM_D_bp stays set, D_stall=1, stall_cnt=4. Assert rst mid-freeze -> next cycle all outputs 0 and stall_cnt=0.
